wt_mult_seq_ctrl: RTL and testbench
===================================

# wt_mult_seq_ctrl

Sequential controller for an iterative carry-save multiplier. It accepts one pair of unsigned operands per transaction over a valid/ready handshake. It then feeds one partial-product row per cycle through a shared row of 3:2 compressors, holding the running sum and carry vectors in registers. A single carry-propagate add at the end produces the product. It sits between the operand source and the product consumer, and is the area-reduced, time-multiplexed counterpart of the full combinational compressor tree.

## Interface
- `N`, default 8: operand width. The product is 2N bits.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operand pair on `a`/`b` is valid.
- `in_ready`, output, 1: controller can accept operands. High only in IDLE.
- `a`, input, N: multiplicand, unsigned.
- `b`, input, N: multiplier, unsigned.
- `out_valid`, output, 1: `product` is valid.
- `out_ready`, input, 1: consumer accepts the product.
- `product`, output, 2N: a*b.
- `busy`, output, 1: high in REDUCE, RESOLVE and DONE.

## Operation
- **FSM states:** IDLE, REDUCE, RESOLVE, DONE. Two-bit encoding, fixed as IDLE=0, REDUCE=1, RESOLVE=2, DONE=3.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register `a`→A, `b`→B, clear S=0 and C=0, set cnt=0, then go to REDUCE.
- **REDUCE, one row per cycle:**
  - Partial product: pp = zero-extended A ANDed with {2N{B[cnt]}}, then shifted left by cnt. Width is 2N.
  - Update S ← S ^ C ^ pp.
  - Update C ← (majority(S,C,pp) << 1), truncated to 2N bits. Dropped bit 2N is harmless because the arithmetic is mod 2^2N and the final product is below 2^2N.
  - cnt increments each cycle. After the edge that processes cnt=N-1, go to RESOLVE.
  - Every row is processed, including rows where B[cnt]=0. There is no zero-skip, so latency is constant.
- **RESOLVE:**
  - `product` ← S + C, truncated to 2N bits.
  - `out_valid` ← 1.
  - Go to DONE.
- **DONE:**
  - Hold `product` and `out_valid` stable until `out_ready`=1.
  - On the edge where `out_valid`&&`out_ready`: drop `out_valid` and go to IDLE.
- **Ignored input:** `in_valid` outside IDLE is ignored, and `a`/`b` are not sampled. In DONE with `out_ready`=1, the next operand is not accepted on the same edge; one IDLE cycle always follows.
- **cnt:** width clog2(N). It is only meaningful in REDUCE and is cleared on accept.

## Timing
- **Reset values:** with `rst_n`=0, asynchronously:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `product`=0, A=B=S=C=0, cnt=0.
- **Reset mid-transaction:** discards all work. The transaction never produces `out_valid`.
- **Latency:** with the accept edge at T, `out_valid` rises at edge T+N+1 (REDUCE is N edges, RESOLVE is 1). For N=8, that is 9 cycles.
- **Throughput:** one product per N+3 cycles with `out_ready` tied high (accept, N reduce, resolve, done, idle).
- **Output registering:** `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Back-pressure:** `product` is stable for every cycle `out_valid`=1, regardless of input activity.

## Structure
- **Package `wt_mult_pkg`:**
  - State enumeration and its encodings.
  - Default N=8.
  - Localparams PW=2N and CW=clog2(N).
- **Sub-module `csa_row`:**
  - Parameter W=2N. Inputs x, y, z; outputs s, c.
  - W-bit bitwise 3:2 compression: s=x^y^z, c=maj(x,y,z).
  - The controller performs the left shift of c.
  - `csa_row` is purely combinational. It is the only datapath shared across cycles.
- **Controller:** holds the FSM, cnt, A/B/S/C registers and the final adder.

## Test plan
- **Basic product:** a=13, b=11, `out_ready`=1 → `out_valid` exactly 9 cycles after accept, `product`=143 (0x008F), one-cycle `out_valid` pulse.
- **Max operands:** a=255, b=255 → `product`=65025 (0xFE01). Exercises dropped carry bit 16. Also cover a=255, b=1 → 255 and a=1, b=128 → 128.
- **Zero operand:** a=0, b=0xA5 → `product`=0, with latency still 9 cycles.
- **Back-pressure:** `out_ready`=0 for 5 cycles after `out_valid` → `product` and `out_valid` held. Toggling `in_valid` with new operands meanwhile is ignored and `in_ready` stays 0. Raise `out_ready` → IDLE next cycle, then the new pair is accepted.
- **Reset mid-REDUCE:** assert `rst_n`=0 at cnt=4 → immediately `out_valid`=0, `in_ready`=1, `product`=0. After release, a=7, b=9 gives 63 with no residue from the aborted pair.
- **Back-to-back:** random sweep of 1000 pairs with random `out_ready` stalls → every product matches a*b in order, with no duplicates or drops.

Source files
------------

// File: rtl/wt_mult_pkg.sv
// wt_mult_pkg: shared state encoding and default sizing for the sequential CSA multiplier.
package wt_mult_pkg;
    localparam int N_DEF = 8;
    localparam int PW = 2 * N_DEF;
    localparam int CW = (N_DEF > 1) ? $clog2(N_DEF) : 1;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/wt_mult_seq_ctrl_csa_row.sv
// csa_row: one row of bitwise 3:2 compressors; the caller shifts the carry vector.
import wt_mult_pkg::*;

module csa_row #(
    parameter int W = PW
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/wt_mult_seq_ctrl.sv
// wt_mult_seq_ctrl: iterative carry-save multiplier, one partial-product row per cycle
// through a shared csa_row, final carry-propagate add in RESOLVE.
import wt_mult_pkg::*;

module wt_mult_seq_ctrl #(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);
    localparam int W    = 2 * N;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    state_t          r_state, w_next;
    logic [N-1:0]    r_a, r_b;
    logic [W-1:0]    r_s, r_c, r_product;
    logic [CNTW-1:0] r_cnt;
    logic [W-1:0]    w_pp, w_sum, w_maj;

    assign w_pp = ({{N{1'b0}}, r_a} & {W{r_b[r_cnt]}}) << r_cnt;

    csa_row #(.W(W)) u_csa (
        .x(r_s),
        .y(r_c),
        .z(w_pp),
        .s(w_sum),
        .c(w_maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? REDUCE : IDLE;
            REDUCE:  w_next = (r_cnt == CNTW'(N - 1)) ? RESOLVE : REDUCE;
            RESOLVE: w_next = DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
    end

    // Carry bit 2N falls off the shift; arithmetic is mod 2^2N and the product fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_s   <= '0;
                r_c   <= '0;
                r_cnt <= '0;
            end
            if (r_state == REDUCE) begin
                r_s   <= w_sum;
                r_c   <= {w_maj[W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == RESOLVE) r_product <= r_s + r_c;
        end
    end

    assign product = r_product;
endmodule

// File: tb/tb_wt_mult_seq_ctrl.sv
// tb_wt_mult_seq_ctrl: directed corner cases plus a random handshake sweep
// scored against a plain a*b queue model.
module tb_wt_mult_seq_ctrl;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;
    logic           busy;

    int checks = 0;
    int failures = 0;
    bit sweep_on = 1'b0;
    int pushes = 0;
    int pops = 0;
    int exp_q[$];

    wt_mult_seq_ctrl #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes complete on the next rising edge; inputs only change just after an edge.
    always @(negedge clk) begin
        if (sweep_on && rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(int'(a) * int'(b));
                pushes++;
            end
            if (out_valid && out_ready) begin
                chk("sweep_prod", 32'(product), exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
                pops++;
            end
        end
    end

    task automatic run_txn(input logic [N-1:0] x, input logic [N-1:0] y, input int stall);
        int lat;
        int w;
        logic [2*N-1:0] held;
        out_ready = (stall == 0);
        w = 0;
        while (!in_ready && w < 30) begin
            step();
            w++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = x;
        b = y;
        step();
        in_valid = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk("latency", lat, N + 1);
        chk("product", 32'(product), int'(x) * int'(y));
        if (stall == 0) begin
            step();
            chk("pulse_valid", 32'(out_valid), 32'd0);
            chk("pulse_idle", 32'(in_ready), 32'd1);
        end else begin
            held = product;
            for (int k = 0; k < stall; k++) begin
                in_valid = k[0];
                a = N'($urandom);
                b = N'($urandom);
                step();
                chk("bp_prod", 32'(product), 32'(held));
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk("bp_rel_valid", 32'(out_valid), 32'd0);
            chk("bp_rel_busy", 32'(busy), 32'd0);
            chk("bp_rel_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_txn(8'd13, 8'd11, 0);
        run_txn(8'd255, 8'd255, 0);
        run_txn(8'd255, 8'd1, 0);
        run_txn(8'd1, 8'd128, 0);
        run_txn(8'd0, 8'hA5, 0);
        run_txn(8'd200, 8'd3, 5);
        run_txn(8'h5A, 8'h3C, 0);

        // Abort a transaction four rows into the reduction.
        in_valid = 1'b1;
        a = 8'd200;
        b = 8'd100;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_txn(8'd7, 8'd9, 0);

        sweep_on = 1'b1;
        while (pushes < 1000) begin
            in_valid = ($urandom_range(3) != 0);
            a = N'($urandom);
            b = N'($urandom);
            out_ready = ($urandom_range(2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && pops < 1000; k++) step();
        step();
        sweep_on = 1'b0;
        chk("sweep_pops", pops, 1000);
        chk("sweep_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
